// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU: op encoding, flag bit positions, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_MUL  = 4'd2,
    ALU_DIV  = 4'd3,
    ALU_SHL  = 4'd4,
    ALU_SHR  = 4'd5,
    ALU_ROL  = 4'd6,
    ALU_ROR  = 4'd7,
    ALU_AND  = 4'd8,
    ALU_OR   = 4'd9,
    ALU_XOR  = 4'd10,
    ALU_NOR  = 4'd11,
    ALU_NAND = 4'd12,
    ALU_XNOR = 4'd13,
    ALU_GT   = 4'd14,
    ALU_EQ   = 4'd15
  } alu_op_e;

  localparam int unsigned FLAG_C   = 0;
  localparam int unsigned FLAG_Z   = 1;
  localparam int unsigned FLAG_N   = 2;
  localparam int unsigned FLAG_V   = 3;
  localparam int unsigned FLAG_DZ  = 4;
  localparam int unsigned NumFlags = 5;

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StDiv  = 2'd1;
  localparam state_t StHold = 2'd2;

endpackage

// File: rtl/alu_seq_if.sv
// Issue/writeback handshake bundle for alu_seq; slave is the ALU, master the surrounding pipeline.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             a;
  logic [WIDTH-1:0]             b;
  logic [3:0]                   op;
  logic                         out_valid;
  logic                         out_ready;
  logic [WIDTH-1:0]             result;
  logic [alu_pkg::NumFlags-1:0] flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_divider.sv
// Unsigned restoring divider, one quotient bit per cycle for WIDTH cycles.
// done marks the cycle of the final step; quotient/remainder then carry that step's result.
module alu_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, quot_q, dvsr_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic [WIDTH:0]   shifted, trial;
  logic             neg;

  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvsr_q};
  // Wrap-around sets the top bit exactly when shifted < divisor.
  assign neg     = trial[WIDTH];

  assign quotient  = {quot_q[WIDTH-2:0], ~neg};
  assign remainder = neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == CntW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      rem_q  <= '0;
      quot_q <= dividend;
      dvsr_q <= divisor;
      cnt_q  <= CntW'(WIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= remainder;
      quot_q <= quotient;
      cnt_q  <= cnt_q - CntW'(1);
      busy_q <= !done;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Registered 16-op ALU with valid/ready handshake, status flags and iterative divider.
// Define ALU_SEQ_SAT_EN for unsigned saturating add/sub (default build wraps).
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DIV_CYCLES = WIDTH
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam int unsigned Msb = WIDTH - 1;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      result_q, result_d;
  logic [NumFlags-1:0]   flags_q, flags_d;

  alu_op_e               op;
  logic [WIDTH:0]        sum, diff;
  logic [2*WIDTH-1:0]    prod;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_c, alu_v;

  logic                  div_start, div_done, div_busy;
  logic [WIDTH-1:0]      div_quot, div_rem;
  logic                  unused_div;

  function automatic logic [NumFlags-1:0] pack_flags(logic [WIDTH-1:0] res, logic c, logic v,
                                                     logic dz);
    logic [NumFlags-1:0] f;
    f          = '0;
    f[FLAG_C]  = c;
    f[FLAG_Z]  = (res == '0);
    f[FLAG_N]  = res[Msb];
    f[FLAG_V]  = v;
    f[FLAG_DZ] = dz;
    return f;
  endfunction

  assign op   = alu_op_e'(bus.op);
  assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};
  assign prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op)
      ALU_ADD: begin
        alu_c = sum[WIDTH];
        alu_v = (bus.a[Msb] == bus.b[Msb]) && (sum[Msb] != bus.a[Msb]);
`ifdef ALU_SEQ_SAT_EN
        alu_res = sum[WIDTH] ? '1 : sum[Msb:0];
`else
        alu_res = sum[Msb:0];
`endif
      end
      ALU_SUB: begin
        alu_c = diff[WIDTH];
        alu_v = (bus.a[Msb] != bus.b[Msb]) && (diff[Msb] != bus.a[Msb]);
`ifdef ALU_SEQ_SAT_EN
        alu_res = diff[WIDTH] ? '0 : diff[Msb:0];
`else
        alu_res = diff[Msb:0];
`endif
      end
      ALU_MUL: begin
        alu_res = prod[Msb:0];
        alu_c   = |prod[2*WIDTH-1:WIDTH];
      end
      ALU_DIV:  alu_res = '0;
      ALU_SHL: begin
        alu_res = {bus.a[Msb-1:0], 1'b0};
        alu_c   = bus.a[Msb];
      end
      ALU_SHR: begin
        alu_res = {1'b0, bus.a[Msb:1]};
        alu_c   = bus.a[0];
      end
      ALU_ROL: begin
        alu_res = {bus.a[Msb-1:0], bus.a[Msb]};
        alu_c   = bus.a[Msb];
      end
      ALU_ROR: begin
        alu_res = {bus.a[0], bus.a[Msb:1]};
        alu_c   = bus.a[0];
      end
      ALU_AND:  alu_res = bus.a & bus.b;
      ALU_OR:   alu_res = bus.a | bus.b;
      ALU_XOR:  alu_res = bus.a ^ bus.b;
      ALU_NOR:  alu_res = ~(bus.a | bus.b);
      ALU_NAND: alu_res = ~(bus.a & bus.b);
      ALU_XNOR: alu_res = ~(bus.a ^ bus.b);
      ALU_GT:   alu_res = {{(WIDTH-1){1'b0}}, bus.a > bus.b};
      ALU_EQ:   alu_res = {{(WIDTH-1){1'b0}}, bus.a == bus.b};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    div_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (op != ALU_DIV) begin
            result_d = alu_res;
            flags_d  = pack_flags(alu_res, alu_c, alu_v, 1'b0);
            state_d  = StHold;
          end else if (bus.b == '0) begin
            result_d = '1;
            flags_d  = pack_flags('1, 1'b0, 1'b0, 1'b1);
            state_d  = StHold;
          end else begin
            div_start = 1'b1;
            state_d   = StDiv;
          end
        end
      end
      StDiv: begin
        if (div_done) begin
          result_d = div_quot;
          flags_d  = pack_flags(div_quot, 1'b0, 1'b0, 1'b0);
          state_d  = StHold;
        end
      end
      StHold: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  alu_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (bus.a),
    .divisor   (bus.b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot),
    .remainder (div_rem)
  );

  assign unused_div = ^{div_rem, div_busy};

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StHold);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8; expectations follow ALU_SEQ_SAT_EN.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8)) bus();

  alu_seq #(
    .WIDTH      (8),
    .DIV_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] top);
    bus.a        = ta;
    bus.b        = tb;
    bus.op       = top;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Latency counted from the acceptance edge; bounded so a stuck DUT still reaches the summary.
  task automatic wait_out(input string tag, input int exp_lat);
    int   lat = 1;
    logic saw_ready = 1'b0;
    while (!bus.out_valid && lat < 40) begin
      saw_ready |= bus.in_ready;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    if (exp_lat > 1) chk({tag, "_busy_ready"}, {31'd0, saw_ready}, 32'd0);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] r, input logic [4:0] f);
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_result"}, {24'd0, bus.result}, {24'd0, r});
    chk({tag, "_flags"}, {27'd0, bus.flags}, {27'd0, f});
  endtask

  task automatic drain(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_drain_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_drain_valid"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  // Single-cycle ops whose expectations are identical with or without saturation.
  logic [7:0] t_a   [17] = '{8'h10, 8'h81, 8'h01, 8'h81, 8'h01, 8'hF0, 8'h0F, 8'hFF, 8'h00,
                             8'hFF, 8'hF0, 8'h80, 8'h7F, 8'h33, 8'h7F, 8'h80, 8'h03};
  logic [7:0] t_b   [17] = '{8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h30, 8'h0F, 8'h00,
                             8'hFF, 8'h0F, 8'h7F, 8'h80, 8'h33, 8'h01, 8'h01, 8'h05};
  logic [3:0] t_op  [17] = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11,
                             4'd12, 4'd13, 4'd14, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
  logic [7:0] t_res [17] = '{8'h10, 8'h02, 8'h00, 8'h03, 8'h80, 8'h30, 8'h3F, 8'hF0, 8'hFF,
                             8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h80, 8'h7F, 8'h0F};
  logic [4:0] t_flg [17] = '{5'h01, 5'h01, 5'h03, 5'h01, 5'h05, 5'h00, 5'h00, 5'h04, 5'h04,
                             5'h02, 5'h02, 5'h00, 5'h02, 5'h00, 5'h0C, 5'h08, 5'h00};

`ifdef ALU_SEQ_SAT_EN
  localparam logic [7:0] SubRes  = 8'h00;
  localparam logic [4:0] SubFlg  = 5'h03;
  localparam logic [7:0] OvfRes  = 8'hFF;
  localparam logic [4:0] OvfFlg  = 5'h0D;
`else
  localparam logic [7:0] SubRes  = 8'hF8;
  localparam logic [4:0] SubFlg  = 5'h05;
  localparam logic [7:0] OvfRes  = 8'h00;
  localparam logic [4:0] OvfFlg  = 5'h0B;
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_result", {24'd0, bus.result}, 32'd0);
    chk("rst_flags", {27'd0, bus.flags}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);

    // Add, latency 1
    issue(8'h0A, 8'h02, 4'd0);
    wait_out("add", 1);
    expect_out("add", 8'h0C, 5'h00);
    drain("add");

    // Sub with borrow
    issue(8'h02, 8'h0A, 4'd1);
    wait_out("sub", 1);
    expect_out("sub", SubRes, SubFlg);
    drain("sub");

    for (int i = 0; i < 17; i++) begin
      issue(t_a[i], t_b[i], t_op[i]);
      wait_out($sformatf("op%0d_%0d", t_op[i], i), 1);
      expect_out($sformatf("op%0d_%0d", t_op[i], i), t_res[i], t_flg[i]);
      drain($sformatf("op%0d_%0d", t_op[i], i));
    end

    // Divide: 8 busy cycles, junk on the inputs must be ignored
    issue(8'hF6, 8'h0A, 4'd3);
    bus.in_valid = 1'b1;
    bus.a        = 8'h00;
    bus.b        = 8'h00;
    bus.op       = 4'd0;
    wait_out("div", 9);
    bus.in_valid = 1'b0;
    expect_out("div", 8'h18, 5'h00);
    drain("div");

    // Hold with out_ready low for 5 cycles
    bus.out_ready = 1'b0;
    issue(8'h80, 8'h80, 4'd0);
    wait_out("hold", 1);
    expect_out("hold", OvfRes, OvfFlg);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      expect_out("hold_stable", OvfRes, OvfFlg);
      chk("hold_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    drain("hold");

    // Divide by zero: immediate, no iteration
    issue(8'h55, 8'h00, 4'd3);
    wait_out("divz", 1);
    expect_out("divz", 8'hFF, 5'h14);
    drain("divz");

    // Asynchronous reset in the middle of a divide
    issue(8'hF6, 8'h0A, 4'd3);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_result", {24'd0, bus.result}, 32'd0);
    chk("midrst_flags", {27'd0, bus.flags}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
    issue(8'h0A, 8'h02, 4'd0);
    wait_out("post_rst_add", 1);
    expect_out("post_rst_add", 8'h0C, 5'h00);
    drain("post_rst_add");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
